// File: rtl/alu_share_arbiter_pkg.sv
// Shared types, ALU control codes and helpers for the shared-ALU arbiter.
package alu_share_arbiter_pkg;

  localparam int unsigned CTRL_W = 4;

  typedef logic [CTRL_W-1:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND = 4'b0000;
  localparam alu_ctrl_t ALU_OR  = 4'b0001;
  localparam alu_ctrl_t ALU_ADD = 4'b0010;
  localparam alu_ctrl_t ALU_SUB = 4'b0110;
  localparam alu_ctrl_t ALU_SLL = 4'b1000;
  localparam alu_ctrl_t ALU_SRL = 4'b1001;
  localparam alu_ctrl_t ALU_SRA = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_legal_alu_ctrl(alu_ctrl_t code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
      default:                                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, shared-ALU and response signals of the shared-ALU arbiter.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned XLEN  = 32
);
  localparam int unsigned ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*CTRL_W-1:0] req_ctrl;
  logic [N_REQ*XLEN-1:0]   req_a;
  logic [N_REQ*XLEN-1:0]   req_b;
  alu_ctrl_t               alu_ctrl;
  logic [XLEN-1:0]         alu_a;
  logic [XLEN-1:0]         alu_b;
  logic [XLEN-1:0]         alu_result;
  logic                    alu_zero;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [XLEN-1:0]         rsp_data;
  logic                    rsp_zero;
  logic                    rsp_err;

  modport slave (
    input  req_valid, req_ctrl, req_a, req_b, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_data,
           rsp_zero, rsp_err
  );

  modport master (
    output req_valid, req_ctrl, req_a, req_b, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_data,
           rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid at or above ptr, with wrap-around.
module rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant_c,
  output logic [ID_W-1:0] idx_c,
  output logic            any_valid_c
);
  localparam int unsigned SUM_W = ID_W + 1;

  logic [SUM_W-1:0] cand_c;
  logic [ID_W-1:0]  cand_idx_c;

  always_comb begin
    grant_c     = '0;
    idx_c       = '0;
    any_valid_c = 1'b0;
    cand_c      = '0;
    cand_idx_c  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_c = SUM_W'(ptr) + SUM_W'(i);
      if (cand_c >= SUM_W'(N)) begin
        cand_c = cand_c - SUM_W'(N);
      end
      cand_idx_c = ID_W'(cand_c);
      if (!any_valid_c && valid[cand_idx_c]) begin
        any_valid_c         = 1'b1;
        idx_c               = cand_idx_c;
        grant_c[cand_idx_c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external ALU between N_REQ requesters with round-robin grant
// and a tagged valid/ready response channel.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned XLEN  = 32
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);
  localparam int unsigned ID_W = id_width(N_REQ);

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  alu_ctrl_t       alu_ctrl_q, alu_ctrl_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0] grant_c;
  logic [ID_W-1:0]  pick_idx_c;
  logic             any_valid_c;
  alu_ctrl_t        sel_ctrl_c;
  logic [XLEN-1:0]  sel_a_c, sel_b_c;
  logic             sel_legal_c;

  rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_rr_pick (
    .valid       (bus.req_valid),
    .ptr         (rr_ptr_q),
    .grant_c     (grant_c),
    .idx_c       (pick_idx_c),
    .any_valid_c (any_valid_c)
  );

  // Operand mux for the candidate winner
  always_comb begin
    sel_ctrl_c = '0;
    sel_a_c    = '0;
    sel_b_c    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_idx_c == ID_W'(i)) begin
        sel_ctrl_c = bus.req_ctrl[i*CTRL_W +: CTRL_W];
        sel_a_c    = bus.req_a[i*XLEN +: XLEN];
        sel_b_c    = bus.req_b[i*XLEN +: XLEN];
      end
    end
    sel_legal_c = is_legal_alu_ctrl(sel_ctrl_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      alu_ctrl_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid_c) state_d = sel_legal_c ? EXEC : RESP;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant capture, result capture and pointer advance; req_ready held low in reset
  always_comb begin
    bus.req_ready = '0;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    alu_ctrl_d    = alu_ctrl_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (any_valid_c && rst_n) begin
          bus.req_ready = grant_c;
          id_d          = pick_idx_c;
          alu_ctrl_d    = sel_ctrl_c;
          alu_a_d       = sel_a_c;
          alu_b_d       = sel_b_c;
          if (!sel_legal_c) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_zero_d  = 1'b0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus.alu_result;
        rsp_zero_d  = bus.alu_zero;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU and response scoreboard.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned XLEN  = 32;

  logic clk;
  logic rst_n;

  alu_share_arbiter_if #(.N_REQ(N_REQ), .XLEN(XLEN)) bus ();

  alu_share_arbiter #(.N_REQ(N_REQ), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU standing in for the shared external unit
  always_comb begin
    case (bus.alu_ctrl)
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      ALU_SLL: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      ALU_SRL: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      ALU_SRA: bus.alu_result = 32'($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  typedef struct {
    logic [31:0] id;
    logic [31:0] data;
    logic        zero;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] data, input logic err, input int lat);
    exp_t e;
    e.id   = 32'(id);
    e.data = err ? 32'h0 : data;
    e.zero = !err && (data == 32'h0);
    e.err  = err;
    e.lat  = lat;
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input alu_ctrl_t c, input logic [31:0] a, input logic [31:0] b);
    bus.req_ctrl[i*4 +: 4]   = c;
    bus.req_a[i*32 +: 32]    = a;
    bus.req_b[i*32 +: 32]    = b;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] gnt, input int lat);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_grant"},  gnt, 32'(1) << e.id);
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "_valid"},  32'(bus.rsp_valid), 32'd1);
      chk({tag, "_id"},     32'(bus.rsp_id), e.id);
      chk({tag, "_data"},   bus.rsp_data, e.data);
      chk({tag, "_zero"},   32'(bus.rsp_zero), 32'(e.zero));
      chk({tag, "_err"},    32'(bus.rsp_err), 32'(e.err));
    end
  endtask

  // Waits (bounded) for rsp_valid, recording the grant seen on the way
  task automatic run_one(input string tag);
    int          n;
    logic [31:0] gnt;
    n   = 0;
    gnt = '0;
    forever begin
      @(negedge clk);
      if (bus.req_ready != '0) gnt = 32'(bus.req_ready);
      if (bus.rsp_valid) break;
      n++;
      if (n > 20) break;
    end
    check_rsp(tag, gnt, n);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_alu_ctrl"},  32'(bus.alu_ctrl), 32'd0);
    chk({tag, "_alu_a"},     bus.alu_a, 32'd0);
    chk({tag, "_alu_b"},     bus.alu_b, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(bus.rsp_id), 32'd0);
    chk({tag, "_rsp_data"},  bus.rsp_data, 32'd0);
    chk({tag, "_rsp_zero"},  32'(bus.rsp_zero), 32'd0);
    chk({tag, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] g;
    rst_n         = 1'b1;
    bus.req_valid = '0;
    bus.req_ctrl  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_checks("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single ADD from req0, cycle-by-cycle
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    push(0, 32'd12, 1'b0, 2);
    @(negedge clk);
    g = 32'(bus.req_ready);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t1_exec_ctrl", 32'(bus.alu_ctrl), 32'(ALU_ADD));
    chk("t1_exec_a", bus.alu_a, 32'd5);
    chk("t1_exec_b", bus.alu_b, 32'd7);
    chk("t1_exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_rsp("t1", g, 2);
    chk("t1_alu_ctrl_held", 32'(bus.alu_ctrl), 32'(ALU_ADD));
    @(posedge clk); #1;

    // 2: both valid, alternating grants (rr_ptr=1 after req0 finished)
    set_req(0, ALU_SUB, 32'd9, 32'd9);
    set_req(1, ALU_OR, 32'hF0, 32'h0F);
    bus.req_valid = 2'b11;
    push(1, 32'hFF, 1'b0, 2);
    push(0, 32'h0,  1'b0, 2);
    push(1, 32'hFF, 1'b0, 2);
    push(0, 32'h0,  1'b0, 2);
    run_one("t2a");
    run_one("t2b");
    run_one("t2c");
    run_one("t2d");
    bus.req_valid = 2'b00;
    @(posedge clk); #1;

    // 3: backpressure on response, req1 waits
    bus.rsp_ready = 1'b0;
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    bus.req_valid = 2'b01;
    push(0, 32'd3, 1'b0, 2);
    run_one("t3");
    bus.req_valid = 2'b10;
    set_req(1, ALU_ADD, 32'h10, 32'h20);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t3_hold_id", 32'(bus.rsp_id), 32'd0);
      chk("t3_hold_data", bus.rsp_data, 32'd3);
      chk("t3_hold_zero", 32'(bus.rsp_zero), 32'd0);
      chk("t3_no_grant", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    push(1, 32'h30, 1'b0, 2);
    run_one("t3_req1");
    bus.req_valid = 2'b00;

    // 4: illegal code from req1 answers one cycle after accept
    set_req(1, 4'b0111, 32'h1234, 32'h5678);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    push(1, 32'h0, 1'b1, 1);
    run_one("t4_illegal");
    bus.req_valid = 2'b00;

    // 5: shifts; rr_ptr back at 0 so req0 goes first
    set_req(0, ALU_SRA, 32'h8000_0000, 32'd4);
    set_req(1, ALU_SLL, 32'd1, 32'd31);
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    push(0, 32'hF800_0000, 1'b0, 2);
    push(1, 32'h8000_0000, 1'b0, 2);
    run_one("t5_sra");
    run_one("t5_sll");
    bus.req_valid = 2'b00;

    // 6: leave rr_ptr=1, then reset during EXEC of a second req0 op
    set_req(0, ALU_ADD, 32'd5, 32'd5);
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    push(0, 32'd10, 1'b0, 2);
    run_one("t6_pre");
    set_req(0, ALU_SUB, 32'd8, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_exec_ctrl", 32'(bus.alu_ctrl), 32'(ALU_SUB));
    chk("t6_exec_a", bus.alu_a, 32'd8);
    rst_n = 1'b0;
    #1 reset_checks("t6_rst");
    set_req(0, ALU_AND, 32'hFF, 32'h0F);
    set_req(1, ALU_ADD, 32'd2, 32'd3);
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("t6_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("t6_sb_empty", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(0, 32'h0F, 1'b0, 2);
    push(1, 32'd5, 1'b0, 2);
    run_one("t6_post0");
    run_one("t6_post1");
    bus.req_valid = 2'b00;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
